div_operand_frontend: RTL
=========================

// Module: div_operand_frontend
// PURPOSE
//  Pin-side front end of the unsigned divider. Synchronises an operand strobe and
//  captures dividend then divisor from an 8-bit pin bus. Issues the pair to the
//  divider core over a valid/ready handshake. Holds the core's result and muxes
//  quotient or remainder onto the output pins.
// PARAMETERS
//  WIDTH        8  operand / result width
//  SYNC_STAGES  2  flops in the strobe synchroniser (>=2)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous reset, active low
//  ena        in   1      design enable; low = freeze FSM and registers (sync chain still runs)
//  din        in   WIDTH  operand bus from pins; stable while strobe high
//  din_stb    in   1      asynchronous operand strobe from pin
//  sel_rem    in   1      0 = dout shows quotient, 1 = dout shows remainder
//  op_valid   out  1      operand pair valid to core
//  op_ready   in   1      core accepts operands
//  dividend   out  WIDTH  to core
//  divisor    out  WIDTH  to core
//  res_valid  in   1      core result pulse
//  quotient   in   WIDTH  from core
//  remainder  in   WIDTH  from core
//  dout       out  WIDTH  selected result to pins
//  busy       out  1      high in ISSUE / WAIT_RES
//  done       out  1      high in SHOW
//  dbz        out  1      last result was divide-by-zero
//  ovr        out  1      sticky: strobe arrived while busy
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): FSM=IDLE. op_valid, busy, done, dbz and ovr are 0.
//    dividend, divisor, dout and the result registers are 0. Sync chain is cleared.
//    Reset mid-operation abandons the transaction; the core shares rst_n.
//  - Strobe: din_stb passes SYNC_STAGES flops, then a rising-edge detect.
//    This gives a 1-cycle pulse stb. din is sampled in the stb cycle.
//  - FSM:
//    IDLE     stb -> latch dividend, clear ovr -> GOT_A
//    GOT_A    stb -> latch divisor -> ISSUE
//    ISSUE    op_valid=1; op_valid && op_ready -> WAIT_RES (transfer in that cycle)
//    WAIT_RES res_valid -> latch quotient/remainder, dbz=(divisor==0) -> SHOW
//    SHOW     done=1, result held; stb -> latch new dividend, clear ovr -> GOT_A
//  - dividend/divisor stay stable while op_valid is high. op_valid never drops
//    before the handshake completes.
//  - stb in ISSUE or WAIT_RES: operand ignored, ovr set. ovr holds until the next
//    accepted dividend.
//  - res_valid outside WAIT_RES is ignored.
//  - dout = sel_rem ? rem_q : quo_q. The select is combinational from the registered
//    results. dout keeps the previous result through GOT_A, ISSUE and WAIT_RES.
//  - ena=0: FSM and all data registers hold. A stb pulse in that cycle is lost.
//    op_valid stays at its held value.
//  - Result registers are exactly WIDTH bits. No arithmetic is done in this block
//    except the divisor==0 compare.
// CONFIGURATION
//  DIV_ZERO_BYPASS_EN defined:
//    - In GOT_A, stb with din==0 skips ISSUE/WAIT_RES and goes straight to SHOW.
//    - Loads quotient = all ones (8'hFF), remainder = dividend, dbz=1.
//    - op_valid is never asserted for a zero divisor.
//  Not defined:
//    - A zero divisor is issued to the core like any other operand.
//    - The core's result is passed through unchanged; dbz=1 is still flagged.
// TESTING
//  1. Strobes din=100 then 7; op_ready=1; core returns q=14 r=2.
//     Expect one op_valid handshake, done=1, dout=14; sel_rem=1 -> dout=2.
//  2. 255/1 with op_ready held low 5 cycles.
//     Expect op_valid stable high with operands unchanged, then q=255 r=0, dbz=0.
//  3. 13/0 with DIV_ZERO_BYPASS_EN.
//     Expect no op_valid, dout=8'hFF, sel_rem=1 -> 13, dbz=1.
//     Without the macro: handshake occurs, dbz=1.
//  4. Third strobe in WAIT_RES.
//     Expect ovr=1 and the result unaffected. ovr clears on the next dividend strobe in SHOW.
//  5. rst_n=0 for 1 cycle in WAIT_RES.
//     Expect IDLE and all outputs 0. A later res_valid is ignored until a new operand pair.
//  6. ena=0 during GOT_A plus a strobe.
//     Expect no state change. After ena=1, the next strobe latches the divisor.

Source files
------------

// File: rtl/div_operand_frontend.sv
// div_operand_frontend
//  Pin-side front end of the unsigned divider. Synchronises the asynchronous
//  operand strobe, captures dividend then divisor from the pin bus, hands the
//  pair to the divider core over valid/ready, and holds the returned result
//  for display on the output pins (quotient or remainder, selected by sel_rem).
//
//  Optional build macro: DIV_ZERO_BYPASS_EN
//    When defined, a zero divisor is resolved locally (quotient all ones,
//    remainder = dividend, dbz set) and never offered to the core.
module div_operand_frontend #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    input  logic             din_stb,
    input  logic             sel_rem,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] divisor,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_A,
        S_ISSUE,
        S_WAIT_RES,
        S_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic             stb_prev_q, stb_prev_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovr_q, ovr_d;
    logic             op_valid_q, op_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stb;

    // Synchroniser shift and edge-detect history; these run even when ena is low
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], din_stb};
        stb_prev_d = sync_q[SYNC_STAGES-1];
    end

    assign stb = sync_q[SYNC_STAGES-1] & ~stb_prev_q;

    // Next-state and data-register logic; everything holds while ena is low
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovr_d      = ovr_q;
        if (ena) begin
            case (state_q)
                S_IDLE, S_SHOW: begin
                    if (stb) begin
                        dividend_d = din;
                        ovr_d      = 1'b0;
                        state_d    = S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (stb) begin
                        divisor_d = din;
`ifdef DIV_ZERO_BYPASS_EN
                        if (din == '0) begin
                            // Zero divisor resolved here; the core never sees it
                            quo_d   = '1;
                            rem_d   = dividend_q;
                            dbz_d   = 1'b1;
                            state_d = S_SHOW;
                        end else begin
                            state_d = S_ISSUE;
                        end
`else
                        state_d = S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (stb) ovr_d = 1'b1;
                    if (op_valid_q && op_ready) state_d = S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (stb) ovr_d = 1'b1;
                    if (res_valid) begin
                        quo_d   = quotient;
                        rem_d   = remainder;
                        dbz_d   = (divisor_q == '0);
                        state_d = S_SHOW;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered, decoded from the upcoming state
    always_comb begin
        op_valid_d = (state_d == S_ISSUE);
        busy_d     = (state_d == S_ISSUE) || (state_d == S_WAIT_RES);
        done_d     = (state_d == S_SHOW);
    end

    // State and data registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            stb_prev_q <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovr_q      <= 1'b0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            stb_prev_q <= stb_prev_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ovr_q      <= ovr_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign op_valid = op_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dbz      = dbz_q;
    assign ovr      = ovr_q;
    assign dividend = dividend_q;
    assign divisor  = divisor_q;
    assign dout     = sel_rem ? rem_q : quo_q;

endmodule
